// File: rtl/clock_work_gen.sv
// Time-of-day counter with an internal prescaler, validated load, alarm comparator
// and a 12/24-hour display mapping. Internal counting is always 24-hour.
module clock_work_gen #(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned DIV_W   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mode12,
  input  logic        load,
  input  logic [16:0] time_in,
  input  logic        alarm_set,
  input  logic [10:0] alarm_in,
  input  logic        alarm_en,
  output logic [16:0] time_out,
  output logic [16:0] disp_out,
  output logic        pm,
  output logic        tick,
  output logic        alarm,
  output logic        day_wrap,
  output logic        load_err
);

  localparam logic [DIV_W-1:0] DivMax = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [4:0]       alarm_hour_q, alarm_hour_d;
  logic [5:0]       alarm_min_q, alarm_min_d;
  logic             tick_q, tick_d;
  logic             alarm_pulse_q, alarm_pulse_d;
  logic             day_wrap_q, day_wrap_d;
  logic             load_err_q, load_err_d;

  logic             load_valid;
  logic             adv;
  logic             sec_wrap, min_wrap;
  logic [4:0]       next_hour;
  logic [5:0]       next_min;
  logic [5:0]       next_sec;
  logic [4:0]       disp_hour;

  assign load_valid = (time_in[5:0] <= 6'd59) && (time_in[11:6] <= 6'd59) &&
                      (time_in[16:12] <= 5'd23);
  // Any load, valid or not, swallows a coincident second advance.
  assign adv        = run && (div_q == DivMax) && !load;

  assign sec_wrap  = (sec_q == 6'd59);
  assign min_wrap  = (min_q == 6'd59);
  assign next_sec  = sec_wrap ? 6'd0 : sec_q + 6'd1;
  assign next_min  = !sec_wrap ? min_q : (min_wrap ? 6'd0 : min_q + 6'd1);
  assign next_hour = !(sec_wrap && min_wrap) ? hour_q :
                     ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1);

  always_comb begin
    div_d         = div_q;
    hour_d        = hour_q;
    min_d         = min_q;
    sec_d         = sec_q;
    alarm_hour_d  = alarm_hour_q;
    alarm_min_d   = alarm_min_q;
    tick_d        = 1'b0;
    alarm_pulse_d = 1'b0;
    day_wrap_d    = 1'b0;
    load_err_d    = 1'b0;

    if (load) begin
      if (load_valid) begin
        hour_d = time_in[16:12];
        min_d  = time_in[11:6];
        sec_d  = time_in[5:0];
        div_d  = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (run) begin
      div_d = (div_q == DivMax) ? '0 : div_q + DIV_W'(1);
    end

    if (adv) begin
      hour_d        = next_hour;
      min_d         = next_min;
      sec_d         = next_sec;
      tick_d        = 1'b1;
      day_wrap_d    = (hour_q == 5'd23) && min_wrap && sec_wrap;
      // Compares against the alarm register as held before this edge.
      alarm_pulse_d = alarm_en && (next_sec == 6'd0) && (next_min == alarm_min_q) &&
                      (next_hour == alarm_hour_q);
    end

    if (alarm_set) begin
      alarm_hour_d = alarm_in[10:6];
      alarm_min_d  = alarm_in[5:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      hour_q        <= 5'd0;
      min_q         <= 6'd0;
      sec_q         <= 6'd0;
      alarm_hour_q  <= 5'd0;
      alarm_min_q   <= 6'd0;
      tick_q        <= 1'b0;
      alarm_pulse_q <= 1'b0;
      day_wrap_q    <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      hour_q        <= hour_d;
      min_q         <= min_d;
      sec_q         <= sec_d;
      alarm_hour_q  <= alarm_hour_d;
      alarm_min_q   <= alarm_min_d;
      tick_q        <= tick_d;
      alarm_pulse_q <= alarm_pulse_d;
      day_wrap_q    <= day_wrap_d;
      load_err_q    <= load_err_d;
    end
  end

  always_comb begin
    disp_hour = hour_q;
    if (mode12) begin
      if (hour_q == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_hour = hour_q - 5'd12;
      end
    end
  end

  assign time_out = {hour_q, min_q, sec_q};
  assign disp_out = {disp_hour, min_q, sec_q};
  assign pm       = mode12 && (hour_q >= 5'd12);
  assign tick     = tick_q;
  assign alarm    = alarm_pulse_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_clock_work_gen.sv
// Bench for clock_work_gen: directed steps plus random traffic, checked against a
// seconds-of-day reference model.
module tb_clock_work_gen;

  localparam int unsigned ClkDiv = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        mode12 = 1'b0;
  logic        load = 1'b0;
  logic [16:0] time_in = '0;
  logic        alarm_set = 1'b0;
  logic [10:0] alarm_in = '0;
  logic        alarm_en = 1'b0;
  logic [16:0] time_out, disp_out;
  logic        pm, tick, alarm, day_wrap, load_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  int m_secs, m_div, m_ah, m_am;
  bit m_tick, m_alarm, m_dw, m_lerr;

  always #5 clk = ~clk;

  clock_work_gen #(
    .CLK_DIV(ClkDiv),
    .DIV_W  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mode12   (mode12),
    .load     (load),
    .time_in  (time_in),
    .alarm_set(alarm_set),
    .alarm_in (alarm_in),
    .alarm_en (alarm_en),
    .time_out (time_out),
    .disp_out (disp_out),
    .pm       (pm),
    .tick     (tick),
    .alarm    (alarm),
    .day_wrap (day_wrap),
    .load_err (load_err)
  );

  function automatic logic [16:0] pack(int h, int m, int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_div = 0; m_ah = 0; m_am = 0;
    m_tick = 0; m_alarm = 0; m_dw = 0; m_lerr = 0;
  endtask

  task automatic check_all();
    int h, dh;
    h  = m_secs / 3600;
    dh = h;
    if (mode12) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    check("time_out", 32'(time_out), 32'(pack(h, (m_secs / 60) % 60, m_secs % 60)));
    check("disp_out", 32'(disp_out), 32'(pack(dh, (m_secs / 60) % 60, m_secs % 60)));
    check("pm", 32'(pm), 32'(mode12 && h >= 12));
    check("tick", 32'(tick), 32'(m_tick));
    check("alarm", 32'(alarm), 32'(m_alarm));
    check("day_wrap", 32'(day_wrap), 32'(m_dw));
    check("load_err", 32'(load_err), 32'(m_lerr));
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int h, m, s;
    m_tick = 0; m_alarm = 0; m_dw = 0; m_lerr = 0;
    h = int'(time_in[16:12]);
    m = int'(time_in[11:6]);
    s = int'(time_in[5:0]);
    if (load) begin
      if (h < 24 && m < 60 && s < 60) begin
        m_secs = h * 3600 + m * 60 + s;
        m_div  = 0;
      end else begin
        m_lerr = 1;
      end
    end else if (run) begin
      if (m_div == ClkDiv - 1) begin
        m_div   = 0;
        m_secs  = (m_secs + 1) % 86400;
        m_tick  = 1;
        m_dw    = (m_secs == 0);
        m_alarm = alarm_en && m_ah < 24 && m_am < 60 && (m_secs == m_ah * 3600 + m_am * 60);
      end else begin
        m_div++;
      end
    end
    if (alarm_set) begin
      m_ah = int'(alarm_in[10:6]);
      m_am = int'(alarm_in[5:0]);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cycles(int n);
    repeat (n) step();
  endtask

  task automatic do_load(int h, int m, int s);
    time_in = pack(h, m, s);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
  endtask

  int hrs[4] = '{0, 12, 13, 23};
  int dhr[4] = '{12, 12, 1, 11};
  int pms[4] = '{0, 1, 1, 1};

  initial begin
    model_reset();
    #2 check_all();
    mode12 = 1'b1;
    #1 check("reset_disp12", 32'(disp_out), 32'(pack(12, 0, 0)));
    mode12 = 1'b0;
    #4 rst = 1'b0;

    // Free run: tick every ClkDiv cycles.
    run = 1'b1;
    cycles(12);
    check("three_secs", 32'(time_out), 32'(pack(0, 0, 3)));

    // Day rollover.
    do_load(23, 59, 58);
    cycles(8);
    check("rollover_dw", 32'(day_wrap), 32'd1);
    step();

    // Invalid load leaves time alone.
    do_load(12, 60, 0);
    check("bad_load_err", 32'(load_err), 32'd1);

    // Load coincident with an advance: load wins, no tick.
    for (int i = 0; i < 8 && m_div != ClkDiv - 1; i++) step();
    do_load(5, 6, 7);
    check("load_vs_adv_tick", 32'(tick), 32'd0);
    check("load_vs_adv_time", 32'(time_out), 32'(pack(5, 6, 7)));

    // Alarm fires when enabled, stays quiet when not.
    alarm_in  = {5'd7, 6'd30};
    alarm_set = 1'b1;
    step();
    alarm_set = 1'b0;
    alarm_en  = 1'b1;
    do_load(7, 29, 59);
    cycles(4);
    check("alarm_hit", 32'(alarm), 32'd1);
    alarm_en = 1'b0;
    do_load(7, 29, 59);
    cycles(4);
    check("alarm_masked", 32'(alarm), 32'd0);

    // 12-hour display mapping.
    run    = 1'b0;
    mode12 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_load(hrs[i], 0, 0);
      check("disp12_hour", 32'(disp_out[16:12]), 32'(dhr[i]));
      check("disp12_pm", 32'(pm), 32'(pms[i]));
    end
    mode12 = 1'b0;

    // Hold mid-second then resume from the held prescaler value.
    run = 1'b1;
    cycles(2);
    run = 1'b0;
    cycles(10);
    run = 1'b1;
    cycles(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      mode12    = 1'($urandom_range(0, 1));
      alarm_en  = ($urandom_range(0, 3) != 0);
      load      = ($urandom_range(0, 19) == 0);
      time_in   = $urandom_range(0, 1) ? pack(23, 59, $urandom_range(50, 59)) : 17'($urandom);
      alarm_set = ($urandom_range(0, 15) == 0);
      alarm_in  = {5'(m_secs / 3600), 6'((m_secs / 60) % 60 + 1)};
      step();
    end
    load = 1'b0;
    alarm_set = 1'b0;

    // Reset mid-second, then counting restarts from zero.
    run = 1'b1;
    cycles(2);
    do_reset();
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_work_gen.md
# clock_work_gen

Parametrised time-of-day counter, successor to the 1 Hz clock-work block. Runs from the system clock with an internal prescaler instead of a dedicated 1 Hz clock. Adds run/hold control, a validated synchronous load, 12/24-hour display output, an alarm comparator and a day-rollover pulse. Feeds the display driver and the alarm/buzzer logic.

## Interface
- CLK_DIV, 50_000_000: clk cycles per second; must be ≥ 2.
- DIV_W, 26: prescaler width; must satisfy 2^DIV_W ≥ CLK_DIV.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = prescaler counts and time advances; 0 = prescaler and time hold.
- mode12  in  1  selects the 12-hour format on disp_out/pm; internal counting is always 24-hour.
- load  in  1  one-cycle synchronous load strobe.
- time_in  in  17  {hour[16:12], min[11:6], sec[5:0]}, sampled when load=1.
- alarm_set  in  1  strobe that loads alarm_in into the alarm register.
- alarm_in  in  11  {hour[10:6], min[5:0]}.
- alarm_en  in  1  enables alarm pulses.
- time_out  out  17  {hour, min, sec}, 24-hour format, registered.
- disp_out  out  17  display time; equals time_out when mode12=0; combinational.
- pm  out  1  mode12=1 and hour ≥ 12; otherwise 0; combinational.
- tick  out  1  one-cycle pulse, registered.
- alarm  out  1  one-cycle pulse, registered.
- day_wrap  out  1  one-cycle pulse, registered.
- load_err  out  1  one-cycle pulse, registered.

## Operation
- Prescaler `div` runs 0..CLK_DIV-1 while run=1 and wraps to 0.
  - The second-advance event is `adv` = run & (div == CLK_DIV-1).
- On `adv`, the time advances by one second:
  - sec wraps 59→0 and carries into min.
  - min wraps 59→0 and carries into hour.
  - hour wraps 23→0.
  - Arithmetic is modulo field range, never modulo 2^width.
- On `load` with all fields valid (sec ≤ 59, min ≤ 59, hour ≤ 23):
  - time registers ← time_in;
  - div ← 0;
  - no tick, alarm or day_wrap is generated that cycle.
- On `load` with any field invalid:
  - time and div are unchanged;
  - load_err=1 for one cycle.
- load has priority over `adv` in the same cycle. The advance is discarded, not deferred.
- alarm_set: the alarm register ← alarm_in. Any value is stored unchecked; an out-of-range alarm never matches.
- alarm=1 in the cycle after an `adv` edge if all of the following hold:
  - the new time equals {alarm_hour, alarm_min, 00};
  - alarm_en=1;
  - the comparison uses the alarm register value held before that edge.
- day_wrap=1 in the cycle after the 23:59:59→00:00:00 advance.
- tick=1 in the cycle after every `adv`.
- 12-hour display mapping (mode12=1):
  - hour 0→12, 1..12→same, 13..23→hour-12;
  - min and sec pass through unchanged.
- Reset values:
  - time_out=0, div=0, alarm register=00:00;
  - tick, alarm, day_wrap, load_err = 0;
  - disp_out = {12,0,0} if mode12=1, else 0;
  - pm=0.

## Timing
- tick, alarm and day_wrap assert in the same cycle that time_out first shows the new value. Each is high for exactly one cycle.
- The first `adv` after reset or after a valid load occurs CLK_DIV cycles later with run held at 1.
- run=0 freezes div. Resuming continues from the held div value; there is no reset of the partial second.
- load and alarm_set work regardless of run.
- load_err asserts in the cycle after the invalid load strobe.
- alarm_set and `adv` in the same cycle: the match uses the old alarm value; the new value applies from the next `adv`.
- rst asserted mid-second clears everything immediately (asynchronously). After release, counting restarts from div=0.
- disp_out and pm respond combinationally to mode12 with no cycle delay.

## Test plan
- CLK_DIV=4, reset, run=1 → tick every 4th cycle; time_out reaches 00:00:03 after 12 cycles.
- Load 23:59:58, run 8 cycles → time_out 23:59:59, then 00:00:00 with day_wrap=1 for one cycle.
- Load 12:60:00 → load_err pulse; time_out unchanged. Assert load together with `adv` → loaded value appears with no tick.
- alarm_set 07:30, alarm_en=1, load 07:29:59, advance → alarm pulse when time_out=07:30:00. Repeat with alarm_en=0 → no pulse.
- mode12=1 at hours 0, 12, 13, 23 → disp_out hours 12, 12, 1, 11; pm = 0, 1, 1, 1.
- run=0 for 10 cycles mid-second → time and div frozen. Assert rst mid-second → all outputs return to reset values immediately.
